imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Boot-time controller for the single-cycle RISC-V instruction memory.
- Receives a program as a byte stream from a UART-RX-style valid/ready source and assembles little-endian 32-bit words.
- Writes the words into the instruction memory write port and holds the CPU fetch path (PC stall plus NOP injection) until loading completes.
- In run mode it passes CPU fetches straight through to the memory.

Parameters:
- ADDR_W, 10, instruction memory word-address width; depth = 2**ADDR_W words.
- BASE_WORD, 0, first word address written by a load.
- BOOT_ON_RESET, 1, 1: enter LEN_LO after reset with CPU held; 0: enter RUN after reset (memory pre-initialised).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- boot_req  in  1  single-cycle pulse; starts a (re)load from RUN or ERR
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle
- cpu_addr  in  32  CPU fetch byte address (PC)
- cpu_instr  out  32  instruction to CPU decode
- mem_addr  out  ADDR_W  instruction memory word address
- mem_we  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data (combinational read)
- cpu_hold  out  1  1 = CPU must not advance PC
- load_busy  out  1  state is LEN_LO, LEN_HI, DATA or CHK
- load_done  out  1  sticky; last load completed OK, cleared on boot_req
- load_err  out  1  sticky; length or checksum error, cleared on boot_req
- word_cnt  out  ADDR_W+1  words written in the current or last load

Behaviour:
- Byte transfer occurs on a cycle with rx_valid && rx_ready. rx_ready = 1 exactly in LEN_LO, LEN_HI, DATA and CHK; 0 otherwise.
- Reset values: mem_we=0, mem_wdata=0, word_cnt=0, load_done=0, load_err=0. State is LEN_LO if BOOT_ON_RESET else RUN; cpu_hold=1 if BOOT_ON_RESET else 0.
- Stream format: LEN_LO byte, LEN_HI byte (N = 16-bit word count), then 4N data bytes. The first data byte of each word goes to bits [7:0].
- RUN:
  - cpu_hold=0; mem_addr = cpu_addr[ADDR_W+1:2]; cpu_instr = mem_rdata.
  - boot_req → LEN_LO next cycle; cpu_hold=1 from that cycle; load_done, load_err and word_cnt cleared.
- Non-RUN states: cpu_instr = 32'h00000013 (NOP) and cpu_hold=1.
- LEN_LO → LEN_HI on transfer. LEN_HI → DATA on transfer.
  - If N = 0: go to RUN instead, load_done=1.
  - If N > 2**ADDR_W − BASE_WORD: go to ERR.
- DATA:
  - A 2-bit byte index accumulates bytes.
  - On the 4th byte's transfer the assembled word is registered. The next cycle has mem_we=1, mem_addr = BASE_WORD + word_cnt, mem_wdata = word, and word_cnt increments at the end of that cycle.
  - rx_ready stays 1 during the write cycle, so back-to-back bytes are legal.
- Completion: the cycle after the write of word N, state = RUN (or CHK, see option), load_done=1, cpu_hold=0.
- ERR: load_err=1, cpu_hold=1, rx_ready=0; boot_req → LEN_LO.
- boot_req is ignored in LEN_LO, LEN_HI, DATA and CHK.
- mem_addr wraps modulo 2**ADDR_W (only reachable with BASE_WORD > 0, and the N check prevents it).
- reset_n asserted mid-load: immediate return to reset values. Partially written memory contents are undefined; the bench must not check them.

Optional Feature:
- Macro IMEM_BOOT_CHKSUM_EN.
- Defined:
  - After the last data word, state CHK accepts one byte.
  - If it equals the XOR of all 4N data bytes → RUN with load_done=1; else → ERR.
  - With N = 0 the CHK byte is still required, and the expected value is 0x00.
- Undefined: no CHK state; DATA goes directly to RUN.

Test Plan:
- Reset with BOOT_ON_RESET=1, stream 02 00 B7 50 34 12 17 01 00 00:
  - mem writes addr0=0x123450B7, then addr1=0x00000117.
  - word_cnt=2, load_done=1, cpu_hold=0 one cycle after the 2nd write.
  - cpu_addr=4 → cpu_instr=0x00000117.
- During load, cpu_addr=0 → cpu_instr=0x00000013 and cpu_hold=1 every cycle until done. rx_valid gaps of 0–3 cycles between bytes give identical writes.
- Length error: ADDR_W=4, stream 11 00 (N=17) → ERR, load_err=1, no mem_we. Then boot_req plus stream 01 00 EF 01 80 00 → addr0=0x008001EF, load_done=1.
- Run-time reload: in RUN pulse boot_req → cpu_hold=1 next cycle, load_done=0. Load N=1 word 0x0FF00213 → addr0 rewritten, RUN resumes.
- Reset mid-load: assert reset_n low after 3 data bytes → all outputs at reset values asynchronously. After release, a full stream loads correctly.
- With IMEM_BOOT_CHKSUM_EN, stream 01 00 13 02 10 00 then checksum byte:
  - Checksum 0x01 → RUN, load_done=1.
  - Checksum 0x00 → ERR, load_err=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed program into instruction memory.
// Optional checksum byte after the data is enabled by IMEM_BOOT_CHKSUM_EN.
module imem_boot_loader #(
  parameter int ADDR_W        = 10,
  parameter int BASE_WORD     = 0,
  parameter bit BOOT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              boot_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [31:0]       cpu_addr,
  output logic [31:0]       cpu_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_hold,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LIMIT = (32'd1 << ADDR_W) - 32'(BASE_WORD);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_WORD);

  typedef enum logic [2:0] {
    S_RUN,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_ERR
`ifdef IMEM_BOOT_CHKSUM_EN
    , S_CHK
`endif
  } state_t;

  localparam state_t S_RST = BOOT_ON_RESET ? S_LEN_LO : S_RUN;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] asm_q, asm_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef IMEM_BOOT_CHKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        xfer;
  logic        busy;
  logic        last_wr;
  logic [15:0] n_in;
  logic [31:0] cnt_nx;

  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA: busy = 1'b1;
`ifdef IMEM_BOOT_CHKSUM_EN
      S_CHK: busy = 1'b1;
`endif
      default: busy = 1'b0;
    endcase
  end

  assign xfer    = rx_valid && busy;
  assign n_in    = {rx_data, len_q[7:0]};
  assign cnt_nx  = 32'(cnt_q) + 32'd1;
  assign last_wr = we_q && (cnt_nx == 32'(len_q));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef IMEM_BOOT_CHKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_RUN, S_ERR: begin
        if (boot_req) begin
          state_d = S_LEN_LO;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = n_in;
          idx_d = 2'd0;
`ifdef IMEM_BOOT_CHKSUM_EN
          csum_d = 8'h00;
`endif
          if (n_in == 16'd0) begin
`ifdef IMEM_BOOT_CHKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_RUN;
            done_d  = 1'b1;
`endif
          end else if (32'(n_in) > LIMIT) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (we_q) cnt_d = cnt_q + 1'b1;
        if (last_wr) begin
`ifdef IMEM_BOOT_CHKSUM_EN
          // checksum byte may already arrive during the final write
          if (xfer) begin
            if (rx_data == csum_q) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end else begin
            state_d = S_CHK;
          end
`else
          state_d = S_RUN;
          done_d  = 1'b1;
`endif
        end else if (xfer) begin
`ifdef IMEM_BOOT_CHKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {rx_data, asm_q};
          end else begin
            asm_d = {rx_data, asm_q[23:8]};
          end
        end
      end
`ifdef IMEM_BOOT_CHKSUM_EN
      S_CHK: begin
        if (xfer) begin
          if (rx_data == csum_q) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RST;
      len_q   <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_BOOT_CHKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef IMEM_BOOT_CHKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  wire unused_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

  always_comb begin
    if (state_q == S_RUN) begin
      mem_addr  = cpu_addr[ADDR_W+1:2];
      cpu_instr = mem_rdata;
      cpu_hold  = 1'b0;
    end else begin
      mem_addr  = BASE_A + cnt_q[ADDR_W-1:0];
      cpu_instr = NOP;
      cpu_hold  = 1'b1;
    end
  end

  assign rx_ready  = busy;
  assign load_busy = busy;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign word_cnt  = cnt_q;

endmodule
